// File: rtl/normcoef_sched_if.sv
// Bundle of channel requests, coefficient configuration, multiplier operands and tagged results
// shared between the scheduler and its surroundings.
interface normcoef_sched_if #(
  parameter int NCH = 4,
  parameter int CW  = 2
);
  logic [NCH-1:0]    req_valid;
  logic [16*NCH-1:0] req_data;
  logic [NCH-1:0]    req_ready;
  logic              cfg_we;
  logic [CW-1:0]     cfg_addr;
  logic [15:0]       cfg_data;
  logic              cfg_commit;
  logic [15:0]       mult_din;
  logic [15:0]       mult_coef;
  logic [15:0]       mult_dout;
  logic              res_valid;
  logic [CW-1:0]     res_chan;
  logic [15:0]       res_data;

  modport master (
    output req_valid, req_data, cfg_we, cfg_addr, cfg_data, cfg_commit, mult_dout,
    input  req_ready, mult_din, mult_coef, res_valid, res_chan, res_data
  );

  modport slave (
    input  req_valid, req_data, cfg_we, cfg_addr, cfg_data, cfg_commit, mult_dout,
    output req_ready, mult_din, mult_coef, res_valid, res_chan, res_data
  );
endinterface

// File: rtl/normcoef_sched.sv
// Round-robin scheduler feeding one shared normalizing multiplier, with a double-buffered
// per-channel coefficient table and a channel tag pipeline aligned to the multiplier latency.
module normcoef_sched #(
  parameter int NCH = 4,
  parameter int CW  = 2,
  parameter int LAT = 1
) (
  input logic             clk,
  input logic             reset_n,
  normcoef_sched_if.slave bus
);

  logic [CW-1:0]  ptr;
  logic [CW-1:0]  ptr_nxt;
  logic [CW-1:0]  gidx;
  logic           found;
  logic           xfer;
  logic [NCH-1:0] grant;
  logic [15:0]    sel_data;
  logic [15:0]    sel_coef;
  logic [15:0]    shadow     [NCH];
  logic [15:0]    active     [NCH];
  logic [15:0]    shadow_nxt [NCH];
  logic [LAT:0]   tag_v;
  logic [CW-1:0]  tag_c      [LAT+1];

  function automatic int wrap(input int v);
    return (v >= NCH) ? v - NCH : v;
  endfunction

  // First requester at or after ptr wins; operands are selected alongside the grant.
  always_comb begin
    found    = 1'b0;
    gidx     = '0;
    sel_data = '0;
    sel_coef = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!found && bus.req_valid[wrap(int'(ptr) + k)]) begin
        found    = 1'b1;
        gidx     = CW'(wrap(int'(ptr) + k));
        sel_data = bus.req_data[16*wrap(int'(ptr) + k) +: 16];
        sel_coef = active[wrap(int'(ptr) + k)];
      end
    end
  end

  always_comb begin
    grant = '0;
    if (found) grant[gidx] = 1'b1;
  end

  assign xfer          = found & reset_n;
  assign bus.req_ready = reset_n ? grant : '0;
  assign ptr_nxt       = (int'(gidx) == NCH - 1) ? '0 : gidx + 1'b1;

  // Folding the same-cycle host write in here lets a commit pick it up.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      shadow_nxt[i] = (bus.cfg_we && int'(bus.cfg_addr) == i) ? bus.cfg_data : shadow[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr           <= '0;
      bus.mult_din  <= '0;
      bus.mult_coef <= 16'h8000;
      tag_v         <= '0;
      for (int s = 0; s <= LAT; s++) tag_c[s] <= '0;
      for (int i = 0; i < NCH; i++) begin
        shadow[i] <= 16'h8000;
        active[i] <= 16'h8000;
      end
    end else begin
      if (xfer) begin
        ptr           <= ptr_nxt;
        bus.mult_din  <= sel_data;
        bus.mult_coef <= sel_coef;
        tag_c[0]      <= gidx;
      end
      tag_v <= {tag_v[LAT-1:0], xfer};
      for (int s = 1; s <= LAT; s++) tag_c[s] <= tag_c[s-1];
      for (int i = 0; i < NCH; i++) begin
        shadow[i] <= shadow_nxt[i];
        if (bus.cfg_commit) active[i] <= shadow_nxt[i];
      end
    end
  end

  assign bus.res_valid = tag_v[LAT];
  assign bus.res_chan  = tag_c[LAT];
  assign bus.res_data  = bus.mult_dout;

endmodule

// File: tb/tb_normcoef_sched.sv
// Directed bench for normcoef_sched: arbitration/result table plus hand sequences for
// coefficient commit ordering and mid-stream reset. Includes a one-stage multiplier model.
module tb_normcoef_sched;

  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;

  normcoef_sched_if #(.NCH(4), .CW(2)) bus ();

  normcoef_sched #(.NCH(4), .CW(2), .LAT(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #4 clk = ~clk;

  logic signed [32:0] prod;
  assign prod = $signed(bus.mult_din) * $signed({1'b0, bus.mult_coef});
  always_ff @(posedge clk) bus.mult_dout <= prod[30:15];

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  exp_ready;
    logic        exp_rv;
    logic [1:0]  exp_ch;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_data = d;
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic commit();
    @(negedge clk);
    bus.cfg_commit = 1'b1;
    @(negedge clk);
    bus.cfg_commit = 1'b0;
  endtask

  // One-cycle request on a single channel; result must appear exactly two cycles later.
  task automatic send(input int ch, input logic [15:0] d, input logic [15:0] exp, input string name);
    @(negedge clk);
    bus.req_valid = 4'(1 << ch);
    bus.req_data[16*ch +: 16] = d;
    #1 check({name, "_ready"}, 32'(bus.req_ready), 32'(1 << ch));
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    #1;
    check({name, "_rv"},   32'(bus.res_valid), 32'd1);
    check({name, "_chan"}, 32'(bus.res_chan),  32'(ch));
    check({name, "_data"}, 32'(bus.res_data),  32'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{4'b1111, 4'b0001, 1'b0, 2'd0, 16'h0000};
    vecs[1]  = '{4'b1111, 4'b0010, 1'b0, 2'd0, 16'h0000};
    vecs[2]  = '{4'b1111, 4'b0100, 1'b1, 2'd0, 16'h0100};
    vecs[3]  = '{4'b1111, 4'b1000, 1'b1, 2'd1, 16'h0200};
    vecs[4]  = '{4'b1111, 4'b0001, 1'b1, 2'd2, 16'h0300};
    vecs[5]  = '{4'b1111, 4'b0010, 1'b1, 2'd3, 16'h0400};
    vecs[6]  = '{4'b1111, 4'b0100, 1'b1, 2'd0, 16'h0100};
    vecs[7]  = '{4'b1111, 4'b1000, 1'b1, 2'd1, 16'h0200};
    vecs[8]  = '{4'b0000, 4'b0000, 1'b1, 2'd2, 16'h0300};
    vecs[9]  = '{4'b0000, 4'b0000, 1'b1, 2'd3, 16'h0400};
    vecs[10] = '{4'b0000, 4'b0000, 1'b0, 2'd0, 16'h0000};
    vecs[11] = '{4'b0010, 4'b0010, 1'b0, 2'd0, 16'h0000};
    vecs[12] = '{4'b1010, 4'b1000, 1'b0, 2'd0, 16'h0000};
    vecs[13] = '{4'b1010, 4'b0010, 1'b1, 2'd1, 16'h0200};
    vecs[14] = '{4'b1010, 4'b1000, 1'b1, 2'd3, 16'h0400};
    vecs[15] = '{4'b1010, 4'b0010, 1'b1, 2'd1, 16'h0200};
    vecs[16] = '{4'b0000, 4'b0000, 1'b1, 2'd3, 16'h0400};
    vecs[17] = '{4'b0000, 4'b0000, 1'b1, 2'd1, 16'h0200};
    vecs[18] = '{4'b0100, 4'b0100, 1'b0, 2'd0, 16'h0000};
    vecs[19] = '{4'b0100, 4'b0100, 1'b0, 2'd0, 16'h0000};
    vecs[20] = '{4'b0100, 4'b0100, 1'b1, 2'd2, 16'h0300};
    vecs[21] = '{4'b0000, 4'b0000, 1'b1, 2'd2, 16'h0300};
    vecs[22] = '{4'b0000, 4'b0000, 1'b1, 2'd2, 16'h0300};
    vecs[23] = '{4'b0000, 4'b0000, 1'b0, 2'd0, 16'h0000};

    reset_n        = 1'b0;
    bus.req_valid  = 4'b0001;
    bus.req_data   = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
    bus.cfg_we     = 1'b0;
    bus.cfg_addr   = '0;
    bus.cfg_data   = '0;
    bus.cfg_commit = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", 32'(bus.req_ready), 32'h0);
    check("rst_rv",    32'(bus.res_valid), 32'h0);
    check("rst_chan",  32'(bus.res_chan),  32'h0);
    check("rst_din",   32'(bus.mult_din),  32'h0);
    check("rst_coef",  32'(bus.mult_coef), 32'h8000);
    reset_n       = 1'b1;
    bus.req_valid = '0;

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      bus.req_valid = vecs[i].valid;
      #1;
      check($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'(vecs[i].exp_ready));
      check($sformatf("v%0d_rv", i),    32'(bus.res_valid), 32'(vecs[i].exp_rv));
      if (vecs[i].exp_rv) begin
        check($sformatf("v%0d_chan", i), 32'(bus.res_chan), 32'(vecs[i].exp_ch));
        check($sformatf("v%0d_data", i), 32'(bus.res_data), 32'(vecs[i].exp_data));
      end
    end

    cfg_write(2'd2, 16'h4000);
    send(2, 16'h0800, 16'h0800, "precommit");
    commit();
    send(2, 16'h0800, 16'h0400, "postcommit");
    send(2, 16'hF800, 16'hFC00, "negative");

    // Write, commit and ch1 grant in one cycle: grant still sees the old unity coefficient.
    @(negedge clk);
    bus.cfg_we = 1'b1; bus.cfg_addr = 2'd1; bus.cfg_data = 16'hC000; bus.cfg_commit = 1'b1;
    bus.req_valid = 4'b0010; bus.req_data[31:16] = 16'h1000;
    #1 check("same_ready", 32'(bus.req_ready), 32'h2);
    @(negedge clk);
    bus.cfg_we = 1'b0; bus.cfg_commit = 1'b0; bus.req_valid = '0;
    #1 check("same_coef", 32'(bus.mult_coef), 32'h8000);
    @(negedge clk);
    #1;
    check("same_rv",   32'(bus.res_valid), 32'd1);
    check("same_data", 32'(bus.res_data),  32'h1000);
    send(1, 16'h1000, 16'h1800, "after_same");

    // Two transfers, then reset with one result visible and one still in flight.
    @(negedge clk);
    bus.req_valid = 4'b0011; bus.req_data[15:0] = 16'h1111; bus.req_data[31:16] = 16'h2222;
    #1 check("mid_ready0", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    #1 check("mid_ready1", 32'(bus.req_ready), 32'h2);
    @(negedge clk);
    bus.req_valid = '0;
    #1 check("mid_rv_pre", 32'(bus.res_valid), 32'd1);
    reset_n = 1'b0;
    bus.req_valid = 4'b0011;
    #1;
    check("mid_rst_rv",    32'(bus.res_valid), 32'h0);
    check("mid_rst_chan",  32'(bus.res_chan),  32'h0);
    check("mid_rst_din",   32'(bus.mult_din),  32'h0);
    check("mid_rst_coef",  32'(bus.mult_coef), 32'h8000);
    check("mid_rst_ready", 32'(bus.req_ready), 32'h0);
    repeat (2) @(negedge clk);
    bus.req_valid = '0;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check($sformatf("post_rst_rv%0d", i), 32'(bus.res_valid), 32'h0);
    end
    commit();
    @(negedge clk);
    bus.req_valid = 4'b1111;
    #1 check("post_rst_ptr", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    bus.req_valid = '0;
    send(2, 16'h0800, 16'h0800, "post_rst_tab2");
    send(1, 16'h1000, 16'h1000, "post_rst_tab1");

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/normcoef_sched.md
# normcoef_sched

Time-shared scheduler and coefficient store for one normalizing multiplier (signed 16-bit data × unsigned 16-bit coefficient, 1.0 = 0x8000, product bits [30:15], one registered stage). Up to NCH channel requesters share it via round-robin arbitration with valid/ready handshakes. Each result is tagged with its channel. Per-channel coefficients are double-buffered: host writes go to a shadow table, and a commit makes them active atomically. The block sits between the per-channel raw-data paths and a single multiplier instance in the channel FPGA.

## Interface
- NCH, 4: number of requesting channels (2..8)
- CW, 2: channel index width, ≥ clog2(NCH)
- LAT, 1: multiplier latency in clocks, from inputs presented to product valid
- clk  in  1  master clock, 125 MHz
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NCH  per-channel sample valid
- req_data  in  16*NCH  per-channel signed sample; channel i occupies bits [16i+15:16i]
- req_ready  out  NCH  per-channel grant, combinational
- cfg_we  in  1  shadow-table write strobe
- cfg_addr  in  CW  shadow entry index
- cfg_data  in  16  coefficient, unsigned
- cfg_commit  in  1  single-cycle pulse: copy shadow→active
- mult_din  out  16  multiplier data operand, registered
- mult_coef  out  16  multiplier coefficient operand, registered
- mult_dout  in  16  multiplier result
- res_valid  out  1  result valid
- res_chan  out  CW  channel tag of result
- res_data  out  16  result, equals mult_dout

## Operation
- **Arbiter:** round-robin pointer `ptr`, reset value 0.
  - Each cycle, grant the first i with req_valid[i]=1, scanning from ptr upward modulo NCH. At most one req_ready bit is high, and only for a requesting channel.
  - A transfer occurs when req_valid[i] & req_ready[i].
  - On a transfer, ptr ← (i+1) mod NCH. With no transfer, ptr holds.
  - Requesters may drop valid without a transfer; this is not a protocol error.
- **Issue:** on the edge closing a transfer:
  - mult_din ← req_data[i]
  - mult_coef ← active[i]
  - issue tag pipeline stage 0 ← {valid=1, chan=i}
  - With no transfer, mult_din and mult_coef hold their values and stage-0 valid ← 0.
- **Tag pipeline:** LAT stages delay {valid, chan}.
  - res_valid and res_chan are driven from the last stage.
  - res_data = mult_dout, passed combinationally.
  - There is no backpressure on results; the consumer must accept every cycle.
- **Coefficient tables:** shadow[NCH] and active[NCH], 16 bits each. All entries reset to 0x8000 (unity gain).
  - cfg_we writes shadow[cfg_addr]. Writes with cfg_addr ≥ NCH are ignored.
  - cfg_commit copies every shadow entry to active in one edge.
  - If cfg_we and cfg_commit fall in the same cycle, the write is included in the commit.
- **Arithmetic:** the block does no arithmetic on data. The coefficient range is 0x0000..0xFFFF (gain 0 to ~2.0). Inputs are 13-bit active, so no overflow handling is required.

## Timing
- Throughput: one transfer per cycle, sustained.
- A transfer in cycle k puts operands on mult_din/mult_coef in cycle k+1. res_valid/res_chan/res_data are valid in cycle k+1+LAT, which is cycle k+2 for LAT=1.
- Results leave in issue order; there is no reordering.
- **Commit vs issue:** a grant in the same cycle as cfg_commit uses the pre-commit active value. The first grant after the commit edge uses the new value. Operations already in flight are unaffected.
- **Reset, asynchronous (reset_n low):**
  - req_ready = 0
  - ptr = 0
  - mult_din = 0, mult_coef = 0x8000
  - all tag valids = 0, so res_valid = 0 and res_chan = 0
  - both tables = 0x8000
  - In-flight results are discarded and no stale res_valid appears after reset release.
  - req_ready may assert in the first cycle after release.
- **All idle:** req_ready = 0; res_valid falls LAT+1 cycles after the last transfer.
- **Single requester held valid:** it is granted every cycle, and ptr cycles to its successor after each grant.

## Test plan
- **Reset defaults:** release reset; ch0 sends 0x0100 → res_valid 2 cycles after transfer, res_chan=0, res_data=0x0100 (unity coefficient).
- **Fairness:** all 4 channels valid continuously for 8 cycles → grant order 0,1,2,3,0,1,2,3; one result per cycle with matching tags.
- **Skip idle channels:** only ch1 and ch3 valid, ptr=2 → grants 3,1,3,1, with no idle cycles.
- **Shadow/commit:** write shadow[2]=0x4000, then issue ch2 data 0x0800 → result 0x0800 (not yet committed). Commit, then issue the same data → 0x0400. Negative data 0xF800 after commit → 0xFC00.
- **Same-cycle events:** cfg_we(addr 1, 0xC000) together with cfg_commit, and a ch1 grant in the same cycle → that result uses 0x8000. The next ch1 grant with 0x1000 → 0x1800.
- **Reset mid-stream:** assert reset_n low while 2 results are in flight → outputs go to reset values immediately. After release, no res_valid until new transfers; ptr restarts at 0; tables read 0x8000.
